// File: rtl/comma_aligner.sv
// comma_aligner: finds 10-bit word boundaries on a serial line by locking onto
// K28.5 commas (either running disparity), then emits aligned words with a
// one-cycle valid strobe. Lock is dropped after repeated misaligned commas.
// Optional build macro COMMA_ALIGN_STATS_EN adds the lost_cnt[7:0] output,
// a saturating count of SYNC->HUNT transitions.
//
// state | meaning
// HUNT  | searching every bit position for a comma; phase frozen
// PEND  | boundary chosen, counting consecutive on-boundary commas
// SYNC  | locked; one aligned word emitted on every boundary edge
module comma_aligner #(
  parameter logic [9:0]  COMMA_N    = 10'b0101111100,
  parameter logic [9:0]  COMMA_P    = 10'b1010000011,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       in,
  output logic [9:0] out,
  output logic       valid,
  output logic       sync,
  output logic       comma_det
`ifdef COMMA_ALIGN_STATS_EN
  ,
  output logic [7:0] lost_cnt
`endif
);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  logic [9:0] win_q, win_d;
  logic [3:0] ph_q, ph_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic [1:0] state_q, state_d;
  logic [9:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       det_q, det_d;
  logic       emit;
  logic       comma, boundary, aligned, misaligned;
`ifdef COMMA_ALIGN_STATS_EN
  logic [7:0] lost_q, lost_d;
`endif

  // Window of the ten most recent bits; compares look at the post-edge window
  // so a match means the comma completes on this edge.
  always_comb begin
    win_d      = {in, win_q[9:1]};
    comma      = (win_d == COMMA_N) | (win_d == COMMA_P);
    boundary   = (ph_q == 4'd9);
    aligned    = comma & boundary;
    misaligned = comma & ~boundary;
  end

  // Next-state, phase, lock/loss counters and output register logic.
  always_comb begin
    state_d = state_q;
    ph_d    = boundary ? 4'd0 : ph_q + 4'd1;
    good_d  = good_q;
    bad_d   = bad_q;
    out_d   = out_q;
    valid_d = 1'b0;
    det_d   = 1'b0;
    emit    = 1'b0;
`ifdef COMMA_ALIGN_STATS_EN
    lost_d  = lost_q;
`endif
    case (state_q)
      ST_HUNT: begin
        ph_d = ph_q;
        if (comma) begin
          ph_d   = 4'd0;
          good_d = 4'd1;
          det_d  = 1'b1;
          if (LOCK_C == 4'd1) begin
            state_d = ST_SYNC;
            bad_d   = 4'd0;
            emit    = 1'b1;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (aligned) begin
          good_d = good_q + 4'd1;
          det_d  = 1'b1;
          if (good_q + 4'd1 == LOCK_C) begin
            state_d = ST_SYNC;
            bad_d   = 4'd0;
            emit    = 1'b1;
          end
        end else if (misaligned) begin
          ph_d   = 4'd0;
          good_d = 4'd1;
        end
      end
      ST_SYNC: begin
        emit = boundary;
        if (aligned) begin
          bad_d = 4'd0;
          det_d = 1'b1;
        end else if (misaligned) begin
          bad_d = bad_q + 4'd1;
          if (bad_q + 4'd1 == LOSS_C) begin
            state_d = ST_HUNT;
            good_d  = 4'd0;
            ph_d    = 4'd0;
            emit    = 1'b0;
`ifdef COMMA_ALIGN_STATS_EN
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
`endif
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (emit) begin
      out_d   = win_d;
      valid_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge reloj) begin
    if (reset) begin
      win_q   <= '0;
      ph_q    <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      state_q <= ST_HUNT;
      out_q   <= '0;
      valid_q <= 1'b0;
      det_q   <= 1'b0;
`ifdef COMMA_ALIGN_STATS_EN
      lost_q  <= '0;
`endif
    end else begin
      win_q   <= win_d;
      ph_q    <= ph_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      det_q   <= det_d;
`ifdef COMMA_ALIGN_STATS_EN
      lost_q  <= lost_d;
`endif
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign sync      = (state_q == ST_SYNC);
  assign comma_det = det_q;
`ifdef COMMA_ALIGN_STATS_EN
  assign lost_cnt  = lost_q;
`endif

endmodule

// File: tb/tb_comma_aligner.sv
// tb_comma_aligner: scenario tasks drive the serial line bit by bit; every word
// the aligner should emit is queued at the bit where its boundary falls, and a
// negedge monitor pops and compares on each valid strobe.
module tb_comma_aligner;

  localparam logic [9:0] K_N = 10'h17C;
  localparam logic [9:0] K_P = 10'h283;
  localparam logic [9:0] D_A = 10'h2AA;

  logic       reloj = 1'b0;
  logic       reset = 1'b1;
  logic       in    = 1'b0;
  logic [9:0] out;
  logic       valid, sync, comma_det;
`ifdef COMMA_ALIGN_STATS_EN
  logic [7:0] lost_cnt;
`endif

  int         tests_run = 0;
  int         fails     = 0;
  logic [9:0] exp_q[$];
  logic [9:0] hist      = '0;
  logic [9:0] mon_exp;

  always #5 reloj = ~reloj;

  comma_aligner dut (
    .reloj     (reloj),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .valid     (valid),
    .sync      (sync),
    .comma_det (comma_det)
`ifdef COMMA_ALIGN_STATS_EN
    ,
    .lost_cnt  (lost_cnt)
`endif
  );

  // Scoreboard: every valid strobe must match the oldest queued word.
  always @(negedge reloj) begin
    if (valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: got out=%h, no word expected", out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          fails++;
          $display("FAIL sb_word: got out=%h, expected %h", out, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Shift nbits of w (LSB first); queue the history word at bit emit_idx.
  task automatic send_bits(input logic [9:0] w, input int nbits, input int emit_idx,
                           output int n_det, output int n_val);
    n_det = 0;
    n_val = 0;
    for (int i = 0; i < nbits; i++) begin
      in   = w[i];
      hist = {w[i], hist[9:1]};
      if (i == emit_idx) exp_q.push_back(hist);
      @(posedge reloj);
      #1;
      if (comma_det === 1'b1) n_det++;
      if (valid === 1'b1) n_val++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in    = 1'b0;
    repeat (2) @(posedge reloj);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 1'b0;
    repeat (2) @(posedge reloj);
    #1;
    tests_run++; if (out !== 10'h000)  begin fails++; $display("FAIL rst_out: got %h want 000", out); end
    tests_run++; if (valid !== 1'b0)   begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
    tests_run++; if (sync !== 1'b0)    begin fails++; $display("FAIL rst_sync: got %b want 0", sync); end
    tests_run++; if (comma_det !== 1'b0) begin fails++; $display("FAIL rst_det: got %b want 0", comma_det); end
    reset = 1'b0;
  endtask

  // Three on-boundary commas with two data words between each -> SYNC.
  task automatic test_lock();
    int d, v;
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 1) begin fails++; $display("FAIL lock_acq_det: got %0d want 1", d); end
    tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL lock_acq_sync: got %b want 0", sync); end
    send_bits(D_A, 10, -1, d, v);
    send_bits(D_A, 10, -1, d, v);
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 1) begin fails++; $display("FAIL lock_2nd_det: got %0d want 1", d); end
    tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL lock_2nd_sync: got %b want 0", sync); end
    send_bits(D_A, 10, -1, d, v);
    send_bits(D_A, 10, -1, d, v);
    send_bits(K_N, 10, 9, d, v);
    tests_run++; if (sync !== 1'b1) begin fails++; $display("FAIL lock_3rd_sync: got %b want 1", sync); end
    tests_run++; if (valid !== 1'b1) begin fails++; $display("FAIL lock_3rd_valid: got %b want 1", valid); end
    tests_run++; if (out !== K_N) begin fails++; $display("FAIL lock_3rd_out: got %h want %h", out, K_N); end
    tests_run++; if (v !== 1) begin fails++; $display("FAIL lock_3rd_nval: got %0d want 1", v); end
    tests_run++; if (comma_det !== 1'b1) begin fails++; $display("FAIL lock_3rd_det: got %b want 1", comma_det); end
  endtask

  // Data stream in SYNC: one valid on the last bit of each word, no comma_det.
  task automatic test_stream();
    int d, v;
    for (int k = 0; k < 5; k++) begin
      send_bits(D_A, 10, 9, d, v);
      tests_run++; if (v !== 1) begin fails++; $display("FAIL stream_nval[%0d]: got %0d want 1", k, v); end
      tests_run++; if (valid !== 1'b1) begin fails++; $display("FAIL stream_valid_pos[%0d]: got %b want 1", k, valid); end
      tests_run++; if (d !== 0) begin fails++; $display("FAIL stream_det[%0d]: got %0d want 0", k, d); end
      tests_run++; if (sync !== 1'b1) begin fails++; $display("FAIL stream_sync[%0d]: got %b want 1", k, sync); end
    end
  endtask

  // Commas shifted by 3 bits: lock lost on the 4th, then re-lock at new phase.
  task automatic test_loss_relock();
    int d, v;
    send_bits(10'b010, 3, -1, d, v);
    tests_run++; if (v !== 0) begin fails++; $display("FAIL loss_shift_nval: got %0d want 0", v); end
    for (int k = 0; k < 4; k++) begin
      send_bits(K_N, 10, 6, d, v);
      tests_run++; if (d !== 0) begin fails++; $display("FAIL loss_det[%0d]: got %0d want 0", k, d); end
      tests_run++; if (v !== 1) begin fails++; $display("FAIL loss_nval[%0d]: got %0d want 1", k, v); end
      tests_run++;
      if (sync !== (k < 3)) begin fails++; $display("FAIL loss_sync[%0d]: got %b want %b", k, sync, (k < 3)); end
    end
    for (int k = 0; k < 3; k++) begin
      send_bits((k == 1) ? K_P : K_N, 10, (k == 2) ? 9 : -1, d, v);
      tests_run++; if (d !== 1) begin fails++; $display("FAIL relock_det[%0d]: got %0d want 1", k, d); end
      tests_run++;
      if (sync !== (k == 2)) begin fails++; $display("FAIL relock_sync[%0d]: got %b want %b", k, sync, (k == 2)); end
      tests_run++;
      if (v !== ((k == 2) ? 1 : 0)) begin fails++; $display("FAIL relock_nval[%0d]: got %0d want %0d", k, v, (k == 2) ? 1 : 0); end
    end
  endtask

  // In PEND, a comma 5 bits off realigns with good=1; two more lock.
  task automatic test_pend_realign();
    int d, v;
    do_reset();
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 1) begin fails++; $display("FAIL pend_acq_det: got %0d want 1", d); end
    send_bits(10'b01010, 5, -1, d, v);
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 0) begin fails++; $display("FAIL pend_mis_det: got %0d want 0", d); end
    tests_run++; if (v !== 0) begin fails++; $display("FAIL pend_mis_nval: got %0d want 0", v); end
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 1) begin fails++; $display("FAIL pend_2nd_det: got %0d want 1", d); end
    tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL pend_2nd_sync: got %b want 0", sync); end
    send_bits(K_N, 10, 9, d, v);
    tests_run++; if (sync !== 1'b1) begin fails++; $display("FAIL pend_3rd_sync: got %b want 1", sync); end
    tests_run++; if (valid !== 1'b1) begin fails++; $display("FAIL pend_3rd_valid: got %b want 1", valid); end
  endtask

  // Reset mid-word while in SYNC; no words until a fresh lock.
  task automatic test_reset_mid_word();
    int d, v;
    send_bits(D_A, 4, -1, d, v);
    reset = 1'b1;
    @(posedge reloj);
    #1;
    tests_run++; if (out !== 10'h000) begin fails++; $display("FAIL midrst_out: got %h want 000", out); end
    tests_run++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", valid); end
    tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL midrst_sync: got %b want 0", sync); end
    tests_run++; if (comma_det !== 1'b0) begin fails++; $display("FAIL midrst_det: got %b want 0", comma_det); end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_bits(D_A, 10, -1, d, v);
      tests_run++; if (v !== 0) begin fails++; $display("FAIL midrst_data_nval[%0d]: got %0d want 0", k, v); end
      tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL midrst_data_sync[%0d]: got %b want 0", k, sync); end
    end
    send_bits(K_N, 10, -1, d, v);
    tests_run++; if (d !== 1) begin fails++; $display("FAIL midrst_acq_det: got %0d want 1", d); end
    tests_run++; if (sync !== 1'b0) begin fails++; $display("FAIL midrst_acq_sync: got %b want 0", sync); end
  endtask

`ifdef COMMA_ALIGN_STATS_EN
  // Two lock/loss cycles -> lost_cnt counts both.
  task automatic test_stats();
    int d, v;
    do_reset();
    tests_run++; if (lost_cnt !== 8'd0) begin fails++; $display("FAIL stats_rst: got %0d want 0", lost_cnt); end
    for (int r = 0; r < 2; r++) begin
      send_bits(K_N, 10, -1, d, v);
      send_bits(K_N, 10, -1, d, v);
      send_bits(K_N, 10, 9, d, v);
      send_bits(10'b010, 3, -1, d, v);
      for (int k = 0; k < 4; k++) send_bits(K_N, 10, 6, d, v);
      tests_run++;
      if (lost_cnt !== 8'(r + 1)) begin fails++; $display("FAIL stats_lost[%0d]: got %0d want %0d", r, lost_cnt, r + 1); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_stream();
    test_loss_relock();
    test_pend_realign();
    test_reset_mid_word();
`ifdef COMMA_ALIGN_STATS_EN
    test_stats();
`endif
    @(negedge reloj);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d words never emitted, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
